tiny_mem_arbiter: RTL and testbench
===================================

// Module: tiny_mem_arbiter
// PURPOSE
//  Shares the unified single-ported memory between the Thumb core's instruction-fetch
//  port (read-only) and its data port (read/write). Sits between tiny_thumb_core and
//  tiny_mem_model.
//  - Fixed data-first priority, with a starvation guard for fetch.
//  - Holds a grant across memory wait states.
//  - Counts fetch stall cycles.
// PARAMETERS
//  STARVE_LIMIT  4   consecutive fetch-wait cycles after which fetch wins next arbitration
//  CNT_W         16  width of saturating fetch-stall counter
// PORTS
//  clk           in   1      clock, all state on posedge
//  rst           in   1      asynchronous, active-high reset
//  i_valid       in   1      fetch request
//  i_addr        in   32     fetch byte address
//  i_ready       out  1      fetch transfer completes this cycle
//  i_rdata       out  32     fetch read data, valid when i_ready
//  d_valid       in   1      data request
//  d_we          in   1      1=write, 0=read
//  d_addr        in   32     data byte address
//  d_wdata       in   32     write data
//  d_wstrb       in   4      byte strobes
//  d_ready       out  1      data transfer completes this cycle
//  d_rdata       out  32     data read data, valid when d_ready && !d_we
//  mem_valid     out  1      memory request
//  mem_we        out  1      memory write enable
//  mem_addr      out  32     memory address
//  mem_wdata     out  32     memory write data
//  mem_wstrb     out  4      memory byte strobes
//  mem_ready     in   1      memory completes the access this cycle
//  mem_rdata     in   32     memory read data (combinational w.r.t. mem_addr)
//  i_stall_cnt   out  CNT_W  saturating count of cycles with i_valid && !i_ready
// BEHAVIOUR
//  - FSM states: IDLE, HOLD_I, HOLD_D.
//  - Reset: state=IDLE, starve_cnt=0, i_stall_cnt=0. All outputs are 0 while rst=1,
//    including the combinational ready and mem_* outputs.
//  - IDLE, combinational select:
//    - d_valid && !starve          -> route D.
//    - else if i_valid             -> route I.
//    - else if d_valid             -> route D.
//    - else                        -> mem_valid=0.
//    - starve = (starve_cnt >= STARVE_LIMIT).
//  - Routing:
//    - Routed port drives mem_*. A fetch forces mem_we=0 and mem_wstrb=0.
//    - Routed port's ready = mem_ready. rdata is broadcast from mem_rdata to both ports.
//    - Ready is never asserted to the un-routed port.
//  - Zero-wait: if mem_ready=1 in the routed cycle, the transfer completes that cycle
//    and the state stays IDLE.
//  - Wait: if mem_ready=0, state goes to HOLD_I or HOLD_D. The grant is locked:
//    - Mux stays on the held port until mem_ready=1, then returns to IDLE.
//    - Requester must keep valid and fields stable while valid && !ready.
//    - Dropping valid in HOLD is a protocol error. The arbiter returns to IDLE with
//      mem_valid=0 the same cycle; checked by assertion.
//  - starve_cnt:
//    - Increments (saturating at STARVE_LIMIT) each cycle with i_valid && !i_ready.
//    - Clears on an i_ready cycle or when i_valid=0.
//  - i_stall_cnt: increments on i_valid && !i_ready and saturates at all-ones. It is
//    never cleared except by reset.
//  - Simultaneous i/d requests:
//    - Data wins unless starve. Fetch is then serviced at the earliest IDLE cycle
//      after the data transfer completes.
//    - Exactly one port is ready per cycle, at most.
//  - Reset mid-HOLD: immediate IDLE with mem_valid=0. Pending requests re-arbitrate
//    after rst deasserts.
//  - No address checking or realignment: addresses pass through unchanged.
//  - d_we=1 with wstrb=0 passes through as a no-op write.
// STRUCTURE
//  - tiny_mem_pkg holds:
//    - typedef enum logic [1:0] {ARB_IDLE, ARB_HOLD_I, ARB_HOLD_D} arb_state_t;
//    - typedef enum logic {GNT_I, GNT_D} arb_gnt_t;
//    - localparam MEM_AW=32, MEM_DW=32, MEM_SW=4 (shared with the memory model).
//  - One sub-module, tiny_sat_counter #(W,MAX). It is used for both starve_cnt and
//    i_stall_cnt, with ports inc, clr, q.
// TESTING
//  1. Reset: hold rst=1 with i_valid=d_valid=1 -> all ready and mem_valid are 0;
//     i_stall_cnt=0 after release.
//  2. Fetch only: i_valid=1, i_addr=0x100, mem_ready=1, mem_rdata=0xDEADBEEF
//     -> i_ready=1, i_rdata=0xDEADBEEF, mem_we=0, same cycle.
//  3. Contention: i_valid=d_valid=1, d_we=1, d_addr=0x200, d_wstrb=4'b0011,
//     mem_ready=1 -> D granted cycle 0 (mem_we=1, mem_wstrb=0011); I granted cycle 1.
//     i_stall_cnt=1.
//  4. Wait states: D read with mem_ready low for 3 cycles -> state HOLD_D;
//     mem_addr=d_addr stable; d_ready only in cycle 3.
//     A fetch arriving during HOLD_D is not granted before d_ready.
//  5. Starvation: d_valid held 1 with back-to-back transfers while i_valid=1
//     -> fetch granted on the cycle after starve_cnt reaches 4, i.e. within 5 cycles.
//     starve_cnt clears on i_ready.
//  6. Async reset mid-HOLD_I: assert rst between clock edges -> mem_valid drops
//     immediately; state is IDLE after release; re-issued fetch completes normally.

Source files
------------

// File: rtl/tiny_mem_pkg.sv
// Shared types and bus widths for the tiny Thumb memory subsystem.
// Used by the arbiter and the memory model:
//   arb_state_t, arb_gnt_t, MEM_AW / MEM_DW / MEM_SW.
package tiny_mem_pkg;

    localparam int MEM_AW = 32;
    localparam int MEM_DW = 32;
    localparam int MEM_SW = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_HOLD_I,
        ARB_HOLD_D
    } arb_state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } arb_gnt_t;

endpackage

// File: rtl/tiny_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (async, active-high), inc, clr (wins over inc), q.
// Latency: q updates on the posedge after inc/clr.
module tiny_sat_counter #(
    parameter int           W   = 4,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != MAX)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/tiny_mem_arbiter.sv
// Arbitrates one single-ported memory between the fetch port (read-only) and the data port.
// Ports: i_* fetch, d_* data, mem_* memory side, i_stall_cnt fetch stall counter.
// Zero-wait routing in IDLE; grant is held across memory wait states; data-first with starvation guard.
module tiny_mem_arbiter
    import tiny_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [MEM_AW-1:0] i_addr,
    output logic              i_ready,
    output logic [MEM_DW-1:0] i_rdata,
    input  logic              d_valid,
    input  logic              d_we,
    input  logic [MEM_AW-1:0] d_addr,
    input  logic [MEM_DW-1:0] d_wdata,
    input  logic [MEM_SW-1:0] d_wstrb,
    output logic              d_ready,
    output logic [MEM_DW-1:0] d_rdata,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [MEM_DW-1:0] mem_wdata,
    output logic [MEM_SW-1:0] mem_wstrb,
    input  logic              mem_ready,
    input  logic [MEM_DW-1:0] mem_rdata,
    output logic [CNT_W-1:0]  i_stall_cnt
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t  state;
    arb_gnt_t    route;
    logic        route_vld;
    logic        starve;
    logic        sel_i;
    logic        sel_d;
    logic [SW-1:0] starve_cnt;

    assign starve = (starve_cnt >= SW'(STARVE_LIMIT));

    // In HOLD the mux is locked to the held port; a dropped valid simply
    // leaves nothing routed so the memory sees mem_valid=0 that cycle.
    always_comb begin
        route_vld = 1'b0;
        route     = GNT_D;
        unique case (state)
            ARB_IDLE: begin
                if (d_valid && !starve) begin
                    route_vld = 1'b1;
                    route     = GNT_D;
                end else if (i_valid) begin
                    route_vld = 1'b1;
                    route     = GNT_I;
                end else if (d_valid) begin
                    route_vld = 1'b1;
                    route     = GNT_D;
                end
            end
            ARB_HOLD_I: begin
                route_vld = i_valid;
                route     = GNT_I;
            end
            ARB_HOLD_D: begin
                route_vld = d_valid;
                route     = GNT_D;
            end
            default: begin
                route_vld = 1'b0;
            end
        endcase
        // Reset forces every combinational output low, not just the state.
        if (rst) begin
            route_vld = 1'b0;
        end
    end

    assign sel_i = route_vld && (route == GNT_I);
    assign sel_d = route_vld && (route == GNT_D);

    assign mem_valid = route_vld;
    assign mem_we    = sel_d && d_we;
    assign mem_addr  = sel_d ? d_addr  : (sel_i ? i_addr : '0);
    assign mem_wdata = sel_d ? d_wdata : '0;
    assign mem_wstrb = sel_d ? d_wstrb : '0;

    assign i_ready = sel_i && mem_ready;
    assign d_ready = sel_d && mem_ready;
    assign i_rdata = rst ? '0 : mem_rdata;
    assign d_rdata = rst ? '0 : mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (route_vld && !mem_ready) begin
                        state <= (route == GNT_I) ? ARB_HOLD_I : ARB_HOLD_D;
                    end
                end
                ARB_HOLD_I, ARB_HOLD_D: begin
                    if (!route_vld || mem_ready) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    tiny_sat_counter #(
        .W   (SW),
        .MAX (SW'(STARVE_LIMIT))
    ) u_starve_cnt (
        .clk (clk),
        .rst (rst),
        .inc (i_valid && !i_ready),
        .clr (!i_valid || i_ready),
        .q   (starve_cnt)
    );

    tiny_sat_counter #(
        .W   (CNT_W),
        .MAX ({CNT_W{1'b1}})
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (i_valid && !i_ready),
        .clr (1'b0),
        .q   (i_stall_cnt)
    );

    // A requester must keep valid asserted while its access is held.
    a_hold_i_valid: assert property (@(posedge clk) disable iff (rst)
                                     (state == ARB_HOLD_I) |-> i_valid);
    a_hold_d_valid: assert property (@(posedge clk) disable iff (rst)
                                     (state == ARB_HOLD_D) |-> d_valid);

endmodule

// File: tb/tb_tiny_mem_arbiter.sv
module tb_tiny_mem_arbiter;
    import tiny_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_valid = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rdy = 1'b0;
    logic [31:0] mem_rdata;
    logic [15:0] i_stall_cnt;

    int total = 0;
    int bad = 0;
    int exp_stall = 0;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [0:255];

    tiny_mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_rdy),
        .mem_rdata(mem_rdata), .i_stall_cnt(i_stall_cnt)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, byte-strobed write on completion.
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_valid && mem_we && mem_rdy) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    // Scoreboard: every completed transfer must match the next expected one.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] rd;
        if (!rst && (i_ready || d_ready)) begin
            total++;
            rd = d_ready ? d_rdata : i_rdata;
            if (i_ready && d_ready) begin
                bad++;
                $display("FAIL both_ready: i_ready=%0b d_ready=%0b, required at most one", i_ready, d_ready);
            end else if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: d_ready=%0b addr=%h, required no transfer", d_ready, mem_addr);
            end else begin
                e = sb.pop_front();
                if (d_ready !== e.is_d || mem_addr !== e.addr || (!e.we && rd !== e.data)) begin
                    bad++;
                    $display("FAIL sb_xfer: got port_d=%0b addr=%h rdata=%h, required port_d=%0b addr=%h rdata=%h",
                             d_ready, mem_addr, rd, e.is_d, e.addr, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_d, input logic we, input logic [31:0] a, input logic [31:0] dat);
        exp_t e;
        e.is_d = is_d; e.we = we; e.addr = a; e.data = dat;
        sb.push_back(e);
    endtask

    task automatic check_stall(input string name);
        total++;
        if (i_stall_cnt !== 16'(exp_stall)) begin
            bad++;
            $display("FAIL %s: i_stall_cnt=%0d required %0d", name, i_stall_cnt, exp_stall);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b1; d_valid = 1'b1; mem_rdy = 1'b1;
        i_addr = 32'h100; d_addr = 32'h200;
        repeat (2) @(negedge clk);
        total++;
        if ({i_ready, d_ready, mem_valid, mem_we} !== 4'b0000 || i_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: i_ready=%0b d_ready=%0b mem_valid=%0b i_rdata=%h, required all 0",
                     i_ready, d_ready, mem_valid, i_rdata);
        end
        i_valid = 1'b0; d_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        total++;
        if (dut.state !== ARB_IDLE) begin
            bad++;
            $display("FAIL reset_state: state=%0d required IDLE", dut.state);
        end
        check_stall("reset_stall_cnt");
    endtask

    task automatic test_fetch_only();
        step();
        i_valid = 1'b1; i_addr = 32'h100; mem_rdy = 1'b1;
        push(1'b0, 1'b0, 32'h100, 32'hDEADBEEF);
        @(negedge clk);
        total++;
        if (i_ready !== 1'b1 || i_rdata !== 32'hDEADBEEF || mem_we !== 1'b0 || d_ready !== 1'b0) begin
            bad++;
            $display("FAIL fetch_only: i_ready=%0b i_rdata=%h mem_we=%0b d_ready=%0b, required 1 deadbeef 0 0",
                     i_ready, i_rdata, mem_we, d_ready);
        end
        step();
        i_valid = 1'b0;
        step();
        check_stall("fetch_only_stall");
    endtask

    task automatic test_contention();
        i_valid = 1'b1; i_addr = 32'h104;
        d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678; d_wstrb = 4'b0011;
        mem_rdy = 1'b1;
        push(1'b1, 1'b1, 32'h200, 32'h0);
        push(1'b0, 1'b0, 32'h104, 32'h11111111);
        @(negedge clk);
        total++;
        if (d_ready !== 1'b1 || i_ready !== 1'b0 || mem_we !== 1'b1 || mem_wstrb !== 4'b0011 ||
            mem_wdata !== 32'h12345678) begin
            bad++;
            $display("FAIL contention_c0: d_ready=%0b i_ready=%0b we=%0b wstrb=%b wdata=%h, required 1 0 1 0011 12345678",
                     d_ready, i_ready, mem_we, mem_wstrb, mem_wdata);
        end
        step();
        d_valid = 1'b0; d_we = 1'b0; d_wstrb = 4'b0000;
        @(negedge clk);
        total++;
        if (i_ready !== 1'b1 || d_ready !== 1'b0 || mem_we !== 1'b0 || mem_wstrb !== 4'b0000) begin
            bad++;
            $display("FAIL contention_c1: i_ready=%0b d_ready=%0b we=%0b wstrb=%b, required 1 0 0 0000",
                     i_ready, d_ready, mem_we, mem_wstrb);
        end
        step();
        i_valid = 1'b0;
        exp_stall += 1;
        step();
        check_stall("contention_stall");
    endtask

    task automatic test_wait_states();
        d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h200; mem_rdy = 1'b0;
        // Reads back the earlier strobed write: low half replaced.
        push(1'b1, 1'b0, 32'h200, 32'hCAFE5678);
        push(1'b0, 1'b0, 32'h100, 32'hDEADBEEF);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin i_valid = 1'b1; i_addr = 32'h100; end
            if (c == 3) mem_rdy = 1'b1;
            @(negedge clk);
            total++;
            if (mem_addr !== 32'h200 || d_ready !== (c == 3) || i_ready !== 1'b0 ||
                (c >= 1 && dut.state !== ARB_HOLD_D)) begin
                bad++;
                $display("FAIL wait_c%0d: addr=%h d_ready=%0b i_ready=%0b state=%0d, required 200 %0b 0 HOLD_D",
                         c, mem_addr, d_ready, i_ready, dut.state, (c == 3));
            end
            step();
        end
        d_valid = 1'b0;
        @(negedge clk);
        total++;
        if (i_ready !== 1'b1 || dut.state !== ARB_IDLE) begin
            bad++;
            $display("FAIL wait_fetch_after: i_ready=%0b state=%0d, required 1 IDLE", i_ready, dut.state);
        end
        step();
        i_valid = 1'b0;
        exp_stall += 3;
        step();
        check_stall("wait_stall");
    endtask

    task automatic test_starvation();
        d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        i_valid = 1'b1; i_addr = 32'h104; mem_rdy = 1'b1;
        for (int k = 0; k < 4; k++) push(1'b1, 1'b0, 32'h300, 32'h33333333);
        push(1'b0, 1'b0, 32'h104, 32'h11111111);
        push(1'b1, 1'b0, 32'h300, 32'h33333333);
        for (int c = 0; c < 6; c++) begin
            if (c == 5) i_valid = 1'b0;
            @(negedge clk);
            total++;
            if (c < 4) begin
                if (d_ready !== 1'b1 || i_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL starve_c%0d: d_ready=%0b i_ready=%0b, required 1 0", c, d_ready, i_ready);
                end
            end else if (c == 4) begin
                if (i_ready !== 1'b1 || d_ready !== 1'b0 || dut.starve_cnt !== 3'd4) begin
                    bad++;
                    $display("FAIL starve_grant: i_ready=%0b d_ready=%0b starve_cnt=%0d, required 1 0 4",
                             i_ready, d_ready, dut.starve_cnt);
                end
            end else begin
                if (d_ready !== 1'b1 || dut.starve_cnt !== 3'd0) begin
                    bad++;
                    $display("FAIL starve_clear: d_ready=%0b starve_cnt=%0d, required 1 0", d_ready, dut.starve_cnt);
                end
            end
            step();
        end
        d_valid = 1'b0;
        exp_stall += 4;
        step();
        check_stall("starve_stall");
    endtask

    task automatic test_reset_mid_hold();
        i_valid = 1'b1; i_addr = 32'h104; mem_rdy = 1'b0;
        @(negedge clk);
        total++;
        if (mem_valid !== 1'b1 || i_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_i_start: mem_valid=%0b i_ready=%0b, required 1 0", mem_valid, i_ready);
        end
        step();
        @(negedge clk);
        total++;
        if (dut.state !== ARB_HOLD_I || mem_addr !== 32'h104) begin
            bad++;
            $display("FAIL hold_i_state: state=%0d addr=%h, required HOLD_I 104", dut.state, mem_addr);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (mem_valid !== 1'b0 || i_ready !== 1'b0 || dut.state !== ARB_IDLE) begin
            bad++;
            $display("FAIL async_rst: mem_valid=%0b i_ready=%0b state=%0d, required 0 0 IDLE",
                     mem_valid, i_ready, dut.state);
        end
        step();
        rst = 1'b0; mem_rdy = 1'b1;
        exp_stall = 0;
        push(1'b0, 1'b0, 32'h104, 32'h11111111);
        @(negedge clk);
        total++;
        if (i_ready !== 1'b1) begin
            bad++;
            $display("FAIL refetch: i_ready=%0b, required 1", i_ready);
        end
        step();
        i_valid = 1'b0;
        step();
        check_stall("rst_stall");
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 32'hA5000000 | k;
        mem[8'h40] = 32'hDEADBEEF;
        mem[8'h41] = 32'h11111111;
        mem[8'h80] = 32'hCAFEF00D;
        mem[8'hC0] = 32'h33333333;
        test_reset();
        test_fetch_only();
        test_contention();
        test_wait_states();
        test_starvation();
        test_reset_mid_hold();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: %0d pending, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
